// File: rtl/mem_wb_commit_pkg.sv
// Shared encodings for the MEM/WB commit stage: load opcodes and stall bit indices.
package mem_wb_commit_pkg;

  typedef enum logic [2:0] {
    LOAD_NONE = 3'd0,
    LOAD_LB   = 3'd1,
    LOAD_LBU  = 3'd2,
    LOAD_LH   = 3'd3,
    LOAD_LHU  = 3'd4,
    LOAD_LW   = 3'd5
  } load_op_e;

  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

endpackage

// File: rtl/mem_wb_commit_load_align.sv
// Big-endian load lane extraction with sign/zero extension and misalignment detect.
module load_align
  import mem_wb_commit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        i_load_op,
  input  logic [1:0]        i_addr_lo,
  input  logic [DATA_W-1:0] i_raw,
  output logic [DATA_W-1:0] o_data,
  output logic              o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'd0:    w_byte = i_raw[31:24];
      2'd1:    w_byte = i_raw[23:16];
      2'd2:    w_byte = i_raw[15:8];
      default: w_byte = i_raw[7:0];
    endcase
    // Odd halfword offsets still pick a lane so the debug value is stable.
    w_half = i_addr_lo[1] ? i_raw[15:0] : i_raw[31:16];
  end

  always_comb begin
    o_data     = i_raw;
    o_misalign = 1'b0;
    case (i_load_op)
      LOAD_LB:  o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
      LOAD_LBU: o_data = {{(DATA_W-8){1'b0}}, w_byte};
      LOAD_LH: begin
        o_data     = {{(DATA_W-16){w_half[15]}}, w_half};
        o_misalign = i_addr_lo[0];
      end
      LOAD_LHU: begin
        o_data     = {{(DATA_W-16){1'b0}}, w_half};
        o_misalign = i_addr_lo[0];
      end
      LOAD_LW:  o_misalign = (i_addr_lo != 2'd0);
      default:  o_data = i_raw;
    endcase
  end

endmodule

// File: rtl/mem_wb_commit.sv
// MEM->WB pipeline register: load alignment, write suppression, HI/LO port,
// retired-write counter and misaligned-load pulse.
module mem_wb_commit
  import mem_wb_commit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic              mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [2:0]        mem_load_op,
  input  logic [1:0]        mem_addr_lo,
  input  logic              mem_whilo,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  output logic              wb_wreg,
  output logic [ADDR_W-1:0] wb_wd,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              wb_whilo,
  output logic [DATA_W-1:0] wb_hi,
  output logic [DATA_W-1:0] wb_lo,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  retired_cnt
);

  logic [DATA_W-1:0] w_aligned;
  logic              w_misalign;
  logic              w_bubble;
  logic              w_hold;
  logic              w_commit;

  logic              r_wreg;
  logic [ADDR_W-1:0] r_wd;
  logic [DATA_W-1:0] r_wdata;
  logic              r_whilo;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic              r_mis;
  logic [CNT_W-1:0]  r_cnt;

  load_align #(.DATA_W(DATA_W)) u_align (
    .i_load_op  (mem_load_op),
    .i_addr_lo  (mem_addr_lo),
    .i_raw      (mem_wdata),
    .o_data     (w_aligned),
    .o_misalign (w_misalign)
  );

  // MEM stalled with WB free (and any flush) drains a bubble into WB.
  assign w_bubble = flush || (stall[STALL_MEM] && !stall[STALL_WB]);
  assign w_hold   = stall[STALL_MEM] && stall[STALL_WB];
  assign w_commit = mem_wreg && (mem_wd != '0) && !w_misalign;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wreg  <= 1'b0;
      r_wd    <= '0;
      r_wdata <= '0;
      r_whilo <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_mis   <= 1'b0;
      r_cnt   <= '0;
    end else if (w_bubble) begin
      r_wreg  <= 1'b0;
      r_wd    <= '0;
      r_wdata <= '0;
      r_whilo <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_mis   <= 1'b0;
    end else if (w_hold) begin
      r_mis   <= 1'b0;
    end else begin
      r_wreg  <= w_commit;
      r_wd    <= mem_wd;
      r_wdata <= w_aligned;
      r_whilo <= mem_whilo;
      r_hi    <= mem_hi;
      r_lo    <= mem_lo;
      r_mis   <= w_misalign;
      r_cnt   <= r_cnt + CNT_W'(w_commit);
    end
  end

  assign wb_wreg      = r_wreg;
  assign wb_wd        = r_wd;
  assign wb_wdata     = r_wdata;
  assign wb_whilo     = r_whilo;
  assign wb_hi        = r_hi;
  assign wb_lo        = r_lo;
  assign misalign_err = r_mis;
  assign retired_cnt  = r_cnt;

endmodule

// File: tb/tb_mem_wb_commit.sv
// Directed bench for mem_wb_commit: behavioural model checked every cycle plus literal pins.
module tb_mem_wb_commit;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [5:0]        stall = '0;
  logic              flush = 1'b0;
  logic [ADDR_W-1:0] mem_wd = '0;
  logic              mem_wreg = 1'b0;
  logic [DATA_W-1:0] mem_wdata = '0;
  logic [2:0]        mem_load_op = '0;
  logic [1:0]        mem_addr_lo = '0;
  logic              mem_whilo = 1'b0;
  logic [DATA_W-1:0] mem_hi = '0;
  logic [DATA_W-1:0] mem_lo = '0;
  logic              wb_wreg;
  logic [ADDR_W-1:0] wb_wd;
  logic [DATA_W-1:0] wb_wdata;
  logic              wb_whilo;
  logic [DATA_W-1:0] wb_hi;
  logic [DATA_W-1:0] wb_lo;
  logic              misalign_err;
  logic [CNT_W-1:0]  retired_cnt;

  mem_wb_commit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_load_op(mem_load_op), .mem_addr_lo(mem_addr_lo),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .misalign_err(misalign_err), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Model state: what WB must show after the most recent edge.
  bit          m_wreg, m_whilo, m_mis;
  int unsigned m_wd, m_wdata, m_hi, m_lo, m_cnt;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_wreg = 0; m_whilo = 0; m_mis = 0;
    m_wd = 0; m_wdata = 0; m_hi = 0; m_lo = 0; m_cnt = 0;
  endfunction

  // Access size in bytes; 0 means not a load (raw word passes through).
  function automatic int op_size(input int op);
    case (op)
      1, 2:    return 1;
      3, 4:    return 2;
      5:       return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned load_value(input int op, input int lo, input int unsigned raw);
    int unsigned v;
    int size;
    size = op_size(op);
    if (size == 0 || size == 4) return raw;
    // Big-endian: byte k of the word sits (3-k) bytes up from the LSB.
    if (size == 1) v = (raw / (2 ** (8 * (3 - lo)))) % 256;
    else           v = (raw / (2 ** (16 * (1 - lo / 2)))) % 65536;
    if (op == 1 && v >= 128)   v = v + 32'hFFFF_FF00;
    if (op == 3 && v >= 32768) v = v + 32'hFFFF_0000;
    return v;
  endfunction

  function automatic void model_edge();
    int size;
    bit mis;
    if (flush || (stall[4] && !stall[5])) begin
      m_wreg = 0; m_whilo = 0; m_mis = 0;
      m_wd = 0; m_wdata = 0; m_hi = 0; m_lo = 0;
    end else if (stall[4]) begin
      m_mis = 0;
    end else begin
      size    = op_size(int'(mem_load_op));
      mis     = (size > 1) && ((int'(mem_addr_lo) % size) != 0);
      m_wreg  = mem_wreg && (mem_wd != 0) && !mis;
      m_wd    = mem_wd;
      m_wdata = load_value(int'(mem_load_op), int'(mem_addr_lo), mem_wdata);
      m_whilo = mem_whilo;
      m_hi    = mem_hi;
      m_lo    = mem_lo;
      m_mis   = mis;
      if (m_wreg) m_cnt = (m_cnt + 1) % (2 ** CNT_W);
    end
  endfunction

  always @(posedge clk) if (rst) model_edge();

  task automatic cmp_all(input string tag);
    chk({tag, ".wreg"},  32'(wb_wreg),      32'(m_wreg));
    chk({tag, ".wd"},    32'(wb_wd),        m_wd);
    chk({tag, ".wdata"}, wb_wdata,          m_wdata);
    chk({tag, ".whilo"}, 32'(wb_whilo),     32'(m_whilo));
    chk({tag, ".hi"},    wb_hi,             m_hi);
    chk({tag, ".lo"},    wb_lo,             m_lo);
    chk({tag, ".mis"},   32'(misalign_err), 32'(m_mis));
    chk({tag, ".cnt"},   32'(retired_cnt),  m_cnt);
  endtask

  always @(negedge clk) if (chk_en) cmp_all("model");

  // Drive one MEM vector, let one edge pass, return at the following negedge.
  task automatic step(input logic [5:0] st, input logic fl, input int wd, input logic wr,
                      input logic [31:0] data, input int op, input int lo);
    stall = st; flush = fl; mem_wd = ADDR_W'(wd); mem_wreg = wr; mem_wdata = data;
    mem_load_op = 3'(op); mem_addr_lo = 2'(lo);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    #1;
    cmp_all("reset");
    #20;
    @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;

    // Plain ALU write, then MEM+WB stall hold.
    step(6'b000000, 0, 3, 1, 32'h1234, 0, 0);
    chk("alu.wdata", wb_wdata, 32'h1234);
    chk("alu.cnt", 32'(retired_cnt), 32'd1);
    repeat (3) step(6'b110000, 0, 9, 1, 32'hDEAD, 0, 0);
    chk("hold.wd", 32'(wb_wd), 32'd3);
    chk("hold.cnt", 32'(retired_cnt), 32'd1);
    step(6'b010000, 0, 9, 1, 32'hDEAD, 0, 0);
    chk("bubble.wreg", 32'(wb_wreg), 32'd0);
    step(6'b000000, 0, 5, 1, 32'hABCD, 0, 0);
    step(6'b110000, 1, 6, 1, 32'hBEEF, 0, 0);
    chk("flush.wdata", wb_wdata, 32'd0);
    chk("flush.cnt", 32'(retired_cnt), 32'd2);

    // Byte/half extraction on 0x8070_6050.
    step(6'b0, 0, 7, 1, 32'h8070_6050, 1, 0);
    chk("lb0", wb_wdata, 32'hFFFF_FF80);
    step(6'b0, 0, 7, 1, 32'h8070_6050, 2, 0);
    chk("lbu0", wb_wdata, 32'h0000_0080);
    step(6'b0, 0, 7, 1, 32'h8070_6050, 1, 3);
    chk("lb3", wb_wdata, 32'h0000_0050);
    step(6'b0, 0, 7, 1, 32'h8070_6050, 4, 2);
    chk("lhu2", wb_wdata, 32'h0000_6050);
    step(6'b0, 0, 7, 1, 32'h8070_6050, 3, 0);
    chk("lh0", wb_wdata, 32'hFFFF_8070);
    step(6'b0, 0, 7, 1, 32'h8070_6050, 7, 1);
    chk("rsvd", wb_wdata, 32'h8070_6050);
    chk("bytes.cnt", 32'(retired_cnt), 32'd8);

    // Misaligned LW / LH: write suppressed, one-cycle pulse.
    step(6'b0, 0, 8, 1, 32'h1111_2222, 5, 2);
    chk("lw2.wreg", 32'(wb_wreg), 32'd0);
    chk("lw2.mis", 32'(misalign_err), 32'd1);
    chk("lw2.wd", 32'(wb_wd), 32'd8);
    step(6'b0, 0, 0, 1, 32'h0, 0, 0);
    chk("lw2.mis_drop", 32'(misalign_err), 32'd0);
    chk("r0.wreg", 32'(wb_wreg), 32'd0);
    step(6'b0, 0, 8, 1, 32'h8070_6050, 3, 1);
    chk("lh1.mis", 32'(misalign_err), 32'd1);
    step(6'b110000, 0, 8, 1, 32'h0, 0, 0);
    chk("lh1.hold_mis", 32'(misalign_err), 32'd0);
    chk("mis.cnt", 32'(retired_cnt), 32'd8);

    // HI/LO independent of the register write.
    mem_whilo = 1'b1; mem_hi = 32'hA; mem_lo = 32'hB;
    step(6'b0, 0, 4, 0, 32'h0, 0, 0);
    chk("hilo.whilo", 32'(wb_whilo), 32'd1);
    chk("hilo.hi", wb_hi, 32'hA);
    chk("hilo.lo", wb_lo, 32'hB);
    chk("hilo.wreg", 32'(wb_wreg), 32'd0);
    mem_whilo = 1'b0; mem_hi = '0; mem_lo = '0;

    // Asynchronous reset while a write is live.
    step(6'b0, 0, 2, 1, 32'h55, 0, 0);
    chk("pre_rst.wreg", 32'(wb_wreg), 32'd1);
    chk_en = 1'b0;
    #1 rst = 1'b0;
    #1;
    model_reset();
    cmp_all("async_rst");
    @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;

    // Counter wrap at CNT_W=4: 16 writes return it to zero.
    for (int i = 0; i < 16; i++) begin
      step(6'b0, 0, (i % 31) + 1, 1, 32'(i), 0, 0);
      if (i == 8) chk("wrap.mid", 32'(retired_cnt), 32'd9);
    end
    chk("wrap.cnt", 32'(retired_cnt), 32'd0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
